// File: rtl/rs_dispatch_router_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rs_dispatch_router_if                                         |
// | Purpose  : Bundles the decode-side handshake and the reservation-station |
// |            busy/write/payload bus of the RS dispatch router.             |
// | Signals  : in_valid/in_ready/in_type/in_payload  decode handshake        |
// |            *_rs_busy   per-RS occupied flags from the RS banks           |
// |            *_rs_write  registered one-hot write strobes to the RS banks  |
// |            rs_payload  registered payload for the strobed RS             |
// | Modports : master = decode + RS banks side, slave = router side          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface rs_dispatch_router_if #(
   parameter int N_ALU_RS    = 4,
   parameter int N_AGU_RS    = 2,
   parameter int N_BRANCH_RS = 2,
   parameter int PAYLOAD_W   = 96
);
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_type;
   logic [PAYLOAD_W-1:0]   in_payload;
   logic [N_ALU_RS-1:0]    alu_rs_busy;
   logic [N_AGU_RS-1:0]    agu_rs_busy;
   logic [N_BRANCH_RS-1:0] branch_rs_busy;
   logic [N_ALU_RS-1:0]    alu_rs_write;
   logic [N_AGU_RS-1:0]    agu_rs_write;
   logic [N_BRANCH_RS-1:0] branch_rs_write;
   logic [PAYLOAD_W-1:0]   rs_payload;

   modport master (
      output in_valid, in_type, in_payload, alu_rs_busy, agu_rs_busy, branch_rs_busy,
      input  in_ready, alu_rs_write, agu_rs_write, branch_rs_write, rs_payload
   );

   modport slave (
      input  in_valid, in_type, in_payload, alu_rs_busy, agu_rs_busy, branch_rs_busy,
      output in_ready, alu_rs_write, agu_rs_write, branch_rs_write, rs_payload
   );
endinterface
`default_nettype wire

// File: rtl/rs_dispatch_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rs_dispatch_router                                            |
// | Purpose  : Registered dispatch router between decode/rename and the ALU, |
// |            branch and AGU reservation-station banks. Picks a free RS of  |
// |            the instruction's class (fixed priority or round-robin),      |
// |            issues a one-hot write strobe plus payload one cycle later,   |
// |            masks the RS granted last cycle, supports flush and counts    |
// |            stall cycles (saturating).                                    |
// | Ports    : clk          clock, rising edge                               |
// |            reset_n      synchronous reset, active low                    |
// |            flush        drop the dispatch of this cycle                  |
// |            bus          rs_dispatch_router_if.slave (handshake + RS bus) |
// |            stall        in_valid & ~in_ready (combinational)             |
// |            stall_cycles saturating stall-cycle count                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rs_dispatch_router #(
   parameter int N_ALU_RS    = 4,
   parameter int N_AGU_RS    = 2,
   parameter int N_BRANCH_RS = 2,
   parameter int PAYLOAD_W   = 96,
   parameter int ROUND_ROBIN = 0,
   parameter int STALL_CNT_W = 16
) (
   input  wire logic                   clk,
   input  wire logic                   reset_n,
   input  wire logic                   flush,
   rs_dispatch_router_if.slave         bus,
   output logic                        stall,
   output logic [STALL_CNT_W-1:0]      stall_cycles
);
   localparam int APW = (N_ALU_RS    > 1) ? $clog2(N_ALU_RS)    : 1;
   localparam int GPW = (N_AGU_RS    > 1) ? $clog2(N_AGU_RS)    : 1;
   localparam int BPW = (N_BRANCH_RS > 1) ? $clog2(N_BRANCH_RS) : 1;
   localparam logic [1:0] C_TYPE_ALU = 2'b00;
   localparam logic [1:0] C_TYPE_BR  = 2'b01;

   logic [N_ALU_RS-1:0]    alu_write_q, alu_write_d;
   logic [N_AGU_RS-1:0]    agu_write_q, agu_write_d;
   logic [N_BRANCH_RS-1:0] br_write_q,  br_write_d;
   logic [PAYLOAD_W-1:0]   payload_q,   payload_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [APW-1:0]         alu_ptr_q,   alu_ptr_d;
   logic [GPW-1:0]         agu_ptr_q,   agu_ptr_d;
   logic [BPW-1:0]         br_ptr_q,    br_ptr_d;

   logic [N_ALU_RS-1:0]    alu_free;
   logic [N_AGU_RS-1:0]    agu_free;
   logic [N_BRANCH_RS-1:0] br_free;
   logic                   alu_hit, agu_hit, br_hit;
   logic [APW-1:0]         alu_gidx;
   logic [GPW-1:0]         agu_gidx;
   logic [BPW-1:0]         br_gidx;
   logic                   sel_alu, sel_agu, sel_br;
   logic                   ready, xfer;

   always_comb begin
      int idx;
      idx = 0;

      // The RS strobed last cycle still shows free on its busy input, so the
      // registered strobe is folded in to avoid granting it twice.
      alu_free = ~(bus.alu_rs_busy    | alu_write_q);
      agu_free = ~(bus.agu_rs_busy    | agu_write_q);
      br_free  = ~(bus.branch_rs_busy | br_write_q);

      // Scan starts at the class pointer (round-robin) or at 0 (fixed).
      alu_hit  = 1'b0;
      alu_gidx = '0;
      for (int k = 0; k < N_ALU_RS; k++) begin
         idx = (ROUND_ROBIN != 0) ? int'(alu_ptr_q) + k : k;
         if (idx >= N_ALU_RS) idx = idx - N_ALU_RS;
         if (!alu_hit && alu_free[idx]) begin
            alu_hit  = 1'b1;
            alu_gidx = APW'(idx);
         end
      end

      agu_hit  = 1'b0;
      agu_gidx = '0;
      for (int k = 0; k < N_AGU_RS; k++) begin
         idx = (ROUND_ROBIN != 0) ? int'(agu_ptr_q) + k : k;
         if (idx >= N_AGU_RS) idx = idx - N_AGU_RS;
         if (!agu_hit && agu_free[idx]) begin
            agu_hit  = 1'b1;
            agu_gidx = GPW'(idx);
         end
      end

      br_hit  = 1'b0;
      br_gidx = '0;
      for (int k = 0; k < N_BRANCH_RS; k++) begin
         idx = (ROUND_ROBIN != 0) ? int'(br_ptr_q) + k : k;
         if (idx >= N_BRANCH_RS) idx = idx - N_BRANCH_RS;
         if (!br_hit && br_free[idx]) begin
            br_hit  = 1'b1;
            br_gidx = BPW'(idx);
         end
      end

      // Loads and stores share the AGU class (in_type = 1x).
      sel_alu = (bus.in_type == C_TYPE_ALU);
      sel_br  = (bus.in_type == C_TYPE_BR);
      sel_agu = bus.in_type[1];

      ready = ~flush & ((sel_alu & alu_hit) | (sel_br & br_hit) | (sel_agu & agu_hit));
      xfer  = bus.in_valid & ready;
      stall = bus.in_valid & ~ready;

      alu_write_d = '0;
      agu_write_d = '0;
      br_write_d  = '0;
      alu_ptr_d   = alu_ptr_q;
      agu_ptr_d   = agu_ptr_q;
      br_ptr_d    = br_ptr_q;
      payload_d   = payload_q;

      if (xfer) begin
         payload_d = bus.in_payload;
         if (sel_alu) begin
            alu_write_d[alu_gidx] = 1'b1;
            if (ROUND_ROBIN != 0)
               alu_ptr_d = (alu_gidx == APW'(N_ALU_RS - 1)) ? '0 : alu_gidx + 1'b1;
         end
         if (sel_br) begin
            br_write_d[br_gidx] = 1'b1;
            if (ROUND_ROBIN != 0)
               br_ptr_d = (br_gidx == BPW'(N_BRANCH_RS - 1)) ? '0 : br_gidx + 1'b1;
         end
         if (sel_agu) begin
            agu_write_d[agu_gidx] = 1'b1;
            if (ROUND_ROBIN != 0)
               agu_ptr_d = (agu_gidx == GPW'(N_AGU_RS - 1)) ? '0 : agu_gidx + 1'b1;
         end
      end

      // A stall during flush is recovery, not back-pressure, so it is not counted.
      stall_cnt_d = stall_cnt_q;
      if (stall && !flush && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alu_write_q <= '0;
         agu_write_q <= '0;
         br_write_q  <= '0;
         payload_q   <= '0;
         stall_cnt_q <= '0;
         alu_ptr_q   <= '0;
         agu_ptr_q   <= '0;
         br_ptr_q    <= '0;
      end else begin
         alu_write_q <= alu_write_d;
         agu_write_q <= agu_write_d;
         br_write_q  <= br_write_d;
         payload_q   <= payload_d;
         stall_cnt_q <= stall_cnt_d;
         alu_ptr_q   <= alu_ptr_d;
         agu_ptr_q   <= agu_ptr_d;
         br_ptr_q    <= br_ptr_d;
      end
   end

   assign bus.in_ready        = ready;
   assign bus.alu_rs_write    = alu_write_q;
   assign bus.agu_rs_write    = agu_write_q;
   assign bus.branch_rs_write = br_write_q;
   assign bus.rs_payload      = payload_q;
   assign stall_cycles        = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_rs_dispatch_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rs_dispatch_router                                         |
// | Purpose  : Scoreboard bench for rs_dispatch_router. Two instances share  |
// |            the stimulus: fixed priority with a 16-bit stall counter and  |
// |            round-robin with a 4-bit stall counter. A reference model     |
// |            predicts ready/stall/count each cycle and queues the expected |
// |            strobes; a monitor pops and compares them.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rs_dispatch_router;
   localparam int PW = 96;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   rs_dispatch_router_if #(.N_ALU_RS(4), .N_AGU_RS(2), .N_BRANCH_RS(2), .PAYLOAD_W(PW)) if_fp ();
   rs_dispatch_router_if #(.N_ALU_RS(4), .N_AGU_RS(2), .N_BRANCH_RS(2), .PAYLOAD_W(PW)) if_rr ();

   logic        stall_fp, stall_rr;
   logic [15:0] scnt_fp;
   logic [3:0]  scnt_rr;

   rs_dispatch_router #(.N_ALU_RS(4), .N_AGU_RS(2), .N_BRANCH_RS(2), .PAYLOAD_W(PW),
                        .ROUND_ROBIN(0), .STALL_CNT_W(16)) u_dut_fp (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if_fp.slave),
      .stall(stall_fp), .stall_cycles(scnt_fp));

   rs_dispatch_router #(.N_ALU_RS(4), .N_AGU_RS(2), .N_BRANCH_RS(2), .PAYLOAD_W(PW),
                        .ROUND_ROBIN(1), .STALL_CNT_W(4)) u_dut_rr (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(if_rr.slave),
      .stall(stall_rr), .stall_cycles(scnt_rr));

   // Per-instance views (0 = fixed priority, 1 = round-robin)
   logic          rdy [2];
   logic          stl [2];
   logic [15:0]   scnt [2];
   logic [7:0]    wr_all [2];
   logic [PW-1:0] pay [2];
   assign rdy[0] = if_fp.in_ready;   assign rdy[1] = if_rr.in_ready;
   assign stl[0] = stall_fp;         assign stl[1] = stall_rr;
   assign scnt[0] = scnt_fp;         assign scnt[1] = {12'd0, scnt_rr};
   assign wr_all[0] = {if_fp.branch_rs_write, if_fp.agu_rs_write, if_fp.alu_rs_write};
   assign wr_all[1] = {if_rr.branch_rs_write, if_rr.agu_rs_write, if_rr.alu_rs_write};
   assign pay[0] = if_fp.rs_payload; assign pay[1] = if_rr.rs_payload;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          inst;
      int          cls;   // 0 ALU, 1 branch, 2 AGU
      int          idx;
      logic [PW-1:0] pay;
      int          due;
   } exp_t;
   exp_t sbq[$];

   // Reference model state
   int          m_ptr [2][3];
   int          m_last_cls [2];
   int          m_last_idx [2];
   int          m_cnt [2];
   int          m_cnt_max [2] = '{65535, 15};
   logic [PW-1:0] m_pay [2];

   function automatic string iname(input int inst);
      return (inst == 0) ? "fp" : "rr";
   endfunction

   task automatic chk(input string name, input int inst, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s [%s] cyc=%0d: got %0h, expected %0h", name, iname(inst), cyc, got, exp);
      end
   endtask

   function automatic int n_of(input int cls);
      return (cls == 0) ? 4 : 2;
   endfunction

   function automatic int cls_of(input logic [1:0] t);
      return (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
   endfunction

   // Index the RS that should be granted, or -1 if the class is full.
   function automatic int model_pick(input int inst, input int cls,
                                     input logic [3:0] ab, input logic [1:0] gb, input logic [1:0] bb);
      int n;
      int i;
      bit busy;
      n = n_of(cls);
      for (int k = 0; k < n; k++) begin
         i = (inst == 1) ? (m_ptr[inst][cls] + k) % n : k;
         busy = (cls == 0) ? ab[i] : (cls == 1) ? bb[i] : gb[i];
         if (m_last_cls[inst] == cls && m_last_idx[inst] == i) busy = 1'b1;
         if (!busy) return i;
      end
      return -1;
   endfunction

   task automatic step(input bit rst, input bit v, input logic [1:0] t, input logic [PW-1:0] p,
                       input bit fl, input logic [3:0] ab, input logic [1:0] gb, input logic [1:0] bb);
      int cls;
      int g;
      bit er;
      exp_t e;
      @(negedge clk);
      reset_n = !rst;
      flush   = fl;
      if_fp.in_valid = v; if_fp.in_type = t; if_fp.in_payload = p;
      if_rr.in_valid = v; if_rr.in_type = t; if_rr.in_payload = p;
      if_fp.alu_rs_busy = ab; if_fp.agu_rs_busy = gb; if_fp.branch_rs_busy = bb;
      if_rr.alu_rs_busy = ab; if_rr.agu_rs_busy = gb; if_rr.branch_rs_busy = bb;
      #1;
      if (rst) begin
         for (int inst = 0; inst < 2; inst++) begin
            for (int c = 0; c < 3; c++) m_ptr[inst][c] = 0;
            m_last_cls[inst] = -1;
            m_last_idx[inst] = -1;
            m_cnt[inst] = 0;
            m_pay[inst] = '0;
         end
         mon_en = 1'b1;
         return;
      end
      for (int inst = 0; inst < 2; inst++) begin
         cls = $isunknown(t) ? -1 : cls_of(t);
         g   = (cls < 0) ? -1 : model_pick(inst, cls, ab, gb, bb);
         er  = !fl && (g >= 0);
         if (cls >= 0) chk("in_ready", inst, 128'(rdy[inst]), 128'(er));
         chk("stall", inst, 128'(stl[inst]), 128'(v && !er));
         chk("stall_cycles", inst, 128'(scnt[inst]), 128'(m_cnt[inst]));
         if (v && !er && !fl && m_cnt[inst] < m_cnt_max[inst]) m_cnt[inst]++;
         if (v && er) begin
            e.inst = inst; e.cls = cls; e.idx = g; e.pay = p; e.due = cyc + 1;
            sbq.push_back(e);
            m_pay[inst] = p;
            m_last_cls[inst] = cls;
            m_last_idx[inst] = g;
            if (inst == 1) m_ptr[inst][cls] = (g == n_of(cls) - 1) ? 0 : g + 1;
         end else begin
            m_last_cls[inst] = -1;
            m_last_idx[inst] = -1;
         end
      end
   endtask

   // Monitor: compares the registered strobes against the scoreboard queue.
   initial begin
      int bits;
      int cls;
      int idx;
      int j;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            for (int inst = 0; inst < 2; inst++) begin
               j = -1;
               for (int q = 0; q < sbq.size(); q++)
                  if (j < 0 && sbq[q].inst == inst) j = q;
               bits = $countones(wr_all[inst]);
               if (bits > 1) chk("strobe onehot", inst, 128'(bits), 128'(1));
               if (bits != 0) begin
                  cls = 0; idx = 0;
                  for (int b = 0; b < 8; b++)
                     if (wr_all[inst][b]) begin
                        cls = (b < 4) ? 0 : (b < 6) ? 2 : 1;
                        idx = (b < 4) ? b : (b < 6) ? b - 4 : b - 6;
                     end
                  if (j < 0) begin
                     chk("spurious strobe", inst, 128'(wr_all[inst]), 128'(0));
                  end else begin
                     chk("strobe class", inst, 128'(cls), 128'(sbq[j].cls));
                     chk("strobe index", inst, 128'(idx), 128'(sbq[j].idx));
                     chk("strobe latency", inst, 128'(cyc), 128'(sbq[j].due));
                     chk("strobe payload", inst, 128'(pay[inst]), 128'(sbq[j].pay));
                     sbq.delete(j);
                  end
               end else if (j >= 0 && sbq[j].due <= cyc) begin
                  chk("missing strobe", inst, 128'(0), 128'(1));
                  sbq.delete(j);
               end
               chk("rs_payload", inst, 128'(pay[inst]), 128'(m_pay[inst]));
            end
         end
      end
   end

   initial begin
      logic [PW-1:0] p;
      logic [1:0]    t;
      bit            v;
      if_fp.in_valid = 0; if_fp.in_type = 0; if_fp.in_payload = '0;
      if_rr.in_valid = 0; if_rr.in_type = 0; if_rr.in_payload = '0;
      if_fp.alu_rs_busy = 0; if_fp.agu_rs_busy = 0; if_fp.branch_rs_busy = 0;
      if_rr.alu_rs_busy = 0; if_rr.agu_rs_busy = 0; if_rr.branch_rs_busy = 0;

      // Reset held 3 cycles with a valid instruction present
      repeat (3) step(1, 1, 2'b00, 96'h1, 0, 4'h0, 2'h0, 2'h0);
      // First ALU op, everything free
      step(0, 1, 2'b00, 96'hA1A1_0000_0000_0000_0000_0001, 0, 4'h0, 2'h0, 2'h0);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      // Fixed priority with busy=0101
      step(0, 1, 2'b00, 96'hB2B2_0000_0000_0000_0000_0002, 0, 4'b0101, 2'h0, 2'h0);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      // Lag masking: one free ALU RS, back-to-back ALU ops
      step(0, 1, 2'b00, 96'hC3C3_0000_0000_0000_0000_0003, 0, 4'b1110, 2'h0, 2'h0);
      step(0, 1, 2'b00, 96'hC3C3_0000_0000_0000_0000_0004, 0, 4'b1110, 2'h0, 2'h0);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      // Four loads/stores into an idle AGU bank
      for (int i = 0; i < 4; i++)
         step(0, 1, (i % 2 == 0) ? 2'b10 : 2'b11, 96'(64'hD4D4_0000_0000_0010 + i), 0, 4'h0, 2'h0, 2'h0);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      // Flush drops the offered ALU op
      step(0, 1, 2'b00, 96'hE5E5_0000_0000_0000_0000_0005, 1, 4'h0, 2'h0, 2'h0);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      // Branch bank full for 20 cycles: counter of the narrow instance saturates
      repeat (20) step(0, 1, 2'b01, 96'hF6, 0, 4'h0, 2'h0, 2'b11);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'b11);
      chk("stall_cycles saturated", 1, 128'(scnt[1]), 128'(15));
      step(0, 1, 2'b00, 96'hF7F7_0000_0000_0000_0000_0007, 0, 4'h0, 2'h0, 2'b11);
      step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         t = 2'($urandom);
         if (!v && $urandom_range(0, 3) == 0) t = 2'bxx;
         p = {$urandom, $urandom, $urandom};
         step(0, v, t, p, ($urandom_range(0, 9) == 0),
              4'($urandom & $urandom), 2'($urandom & $urandom), 2'($urandom & $urandom));
      end

      repeat (3) step(0, 0, 2'b00, '0, 0, 4'h0, 2'h0, 2'h0);
      chk("scoreboard drained", 0, 128'(sbq.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
